// File: rtl/rtc_bus_ctrl_pkg.sv
// rtc_bus_pkg: types and constants shared by the RTC bus transaction engine.
//   state_t    - transaction sequencer states
//   T_*_DEF    - default phase timings in clock cycles
//   CW_DEF     - default phase counter width
//   DATA_W     - width of RTC address/data bytes
//   OP_WR/RD   - encoding of the wr_en operand
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SU,
    A_PW,
    A_HD,
    GAP,
    D_SU,
    D_PW,
    D_HD,
    FIN
  } state_t;

  localparam int T_SU_DEF  = 2;
  localparam int T_PW_DEF  = 10;
  localparam int T_HD_DEF  = 2;
  localparam int T_GAP_DEF = 5;
  localparam int CW_DEF    = 8;
  localparam int DATA_W    = 8;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: request/response channel between the RTC register
// sequencer (master) and the bus transaction engine (slave).
//   start  - one-cycle request, honoured only when the engine is free
//   wr_en  - 1 = write, 0 = read
//   addr   - RTC register address
//   wdata  - write byte
//   busy   - transaction in progress
//   done   - one-cycle completion pulse
//   rdata  - last byte read from the RTC
interface rtc_bus_ctrl_if;
  import rtc_bus_pkg::*;

  logic              start;
  logic              wr_en;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output start, wr_en, addr, wdata, input busy, done, rdata);
  modport slave  (input start, wr_en, addr, wdata, output busy, done, rdata);

endinterface

// File: rtl/rtc_bus_ctrl_phase_cnt.sv
// rtc_phase_cnt: loadable down-counter timing each phase of an RTC cycle.
//   clk, rst - clock and asynchronous active-low reset
//   load     - load 'value' into the counter this cycle
//   value    - count to load (phase length minus one)
//   zero     - counter has reached 0; the phase ends this cycle
// The counter parks at 0 until reloaded.
module rtc_phase_cnt
  import rtc_bus_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: runs one complete write or read cycle on the RTC's
// multiplexed bus per request: address phase, turnaround gap, data phase.
//   clk, rst  - clock and asynchronous active-low reset
//   ctrl      - request/response channel (slave side)
//   AD        - 0 = address phase, 1 = data phase / idle
//   CS        - chip select, active low
//   RD, RW    - read / write strobes, active low
//   Dato_sal  - bidirectional RTC data bus, high-Z unless driven here
// Every pin is a flop loaded from the next-state decode, so pins never
// glitch and no input reaches a pin combinationally.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_PW  = T_PW_DEF,
  parameter int T_HD  = T_HD_DEF,
  parameter int T_GAP = T_GAP_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  rtc_bus_ctrl_if.slave     ctrl,
  output logic              AD,
  output logic              CS,
  output logic              RD,
  output logic              RW,
  inout  wire  [DATA_W-1:0] Dato_sal
);

  // The counter holds (phase length - 1) on entry, so a phase lasts T cycles.
  localparam logic [CW-1:0] LV_SU  = CW'(T_SU - 1);
  localparam logic [CW-1:0] LV_PW  = CW'(T_PW - 1);
  localparam logic [CW-1:0] LV_HD  = CW'(T_HD - 1);
  localparam logic [CW-1:0] LV_GAP = CW'(T_GAP - 1);

  state_t            state_q, state_d;
  logic              cnt_load, cnt_zero;
  logic [CW-1:0]     cnt_value;
  logic              op_wr_q, op_wr_d;
  logic [DATA_W-1:0] op_addr_q, op_addr_d, op_wdata_q, op_wdata_d;
  logic              ad_d, cs_d, rd_d, rw_d, oe_d, oe_q, busy_d, busy_q, done_d, done_q;
  logic [DATA_W-1:0] dout_d, dout_q, rdata_q;

  rtc_phase_cnt #(.CW(CW)) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_wr_q    <= OP_RD;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      op_addr_q  <= op_addr_d;
      op_wdata_q <= op_wdata_d;
    end
  end

  // FIN accepts a request exactly like IDLE so back-to-back cycles lose only
  // the single done cycle. Operands are latched only on acceptance, which is
  // what makes a start during a busy cycle harmless.
  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    op_wr_d    = op_wr_q;
    op_addr_d  = op_addr_q;
    op_wdata_d = op_wdata_q;
    unique case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (ctrl.start) begin
          state_d    = A_SU;
          cnt_load   = 1'b1;
          cnt_value  = LV_SU;
          op_wr_d    = ctrl.wr_en;
          op_addr_d  = ctrl.addr;
          op_wdata_d = ctrl.wdata;
        end
      end
      A_SU: if (cnt_zero) begin state_d = A_PW; cnt_load = 1'b1; cnt_value = LV_PW;  end
      A_PW: if (cnt_zero) begin state_d = A_HD; cnt_load = 1'b1; cnt_value = LV_HD;  end
      A_HD: if (cnt_zero) begin state_d = GAP;  cnt_load = 1'b1; cnt_value = LV_GAP; end
      GAP:  if (cnt_zero) begin state_d = D_SU; cnt_load = 1'b1; cnt_value = LV_SU;  end
      D_SU: if (cnt_zero) begin state_d = D_PW; cnt_load = 1'b1; cnt_value = LV_PW;  end
      D_PW: if (cnt_zero) begin state_d = D_HD; cnt_load = 1'b1; cnt_value = LV_HD;  end
      D_HD: if (cnt_zero) begin state_d = FIN; end
      default: state_d = IDLE;
    endcase
  end

  // Pin values are decoded from the state being entered, so the pin flops
  // always show the levels belonging to the current state.
  always_comb begin
    ad_d   = 1'b1;
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    rw_d   = 1'b1;
    oe_d   = 1'b0;
    dout_d = op_wdata_d;
    busy_d = 1'b1;
    done_d = 1'b0;
    unique case (state_d)
      IDLE: busy_d = 1'b0;
      FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      A_SU, A_HD: begin
        ad_d   = 1'b0;
        oe_d   = 1'b1;
        dout_d = op_addr_d;
      end
      A_PW: begin
        ad_d   = 1'b0;
        oe_d   = 1'b1;
        dout_d = op_addr_d;
        cs_d   = 1'b0;
        rw_d   = 1'b0;
      end
      // A read releases the bus from the gap onward so the RTC can turn it.
      GAP, D_SU, D_HD: oe_d = op_wr_d;
      D_PW: begin
        oe_d = op_wr_d;
        cs_d = 1'b0;
        if (op_wr_d) rw_d = 1'b0;
        else         rd_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AD     <= 1'b1;
      CS     <= 1'b1;
      RD     <= 1'b1;
      RW     <= 1'b1;
      oe_q   <= 1'b0;
      dout_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      AD     <= ad_d;
      CS     <= cs_d;
      RD     <= rd_d;
      RW     <= rw_d;
      oe_q   <= oe_d;
      dout_q <= dout_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Read data is taken on the edge that ends the strobe, while the RTC is
  // still guaranteed to be driving the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (state_q == D_PW && cnt_zero && op_wr_q == OP_RD) begin
      rdata_q <= Dato_sal;
    end
  end

  assign Dato_sal   = oe_q ? dout_q : {DATA_W{1'bz}};
  assign ctrl.busy  = busy_q;
  assign ctrl.done  = done_q;
  assign ctrl.rdata = rdata_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: randomized scoreboard bench for rtc_bus_ctrl.
// A behavioural RTC sits on the bus (pulled high when nobody drives it);
// expected pin waveforms come from phase-boundary arithmetic, expected read
// data from a reference register file. A second instance with 1-cycle timing
// covers the minimum-parameter corner.
module tb_rtc_bus_ctrl;
  import rtc_bus_pkg::*;

  localparam int A_LEN    = T_SU_DEF + T_PW_DEF + T_HD_DEF;
  localparam int BUSY_LEN = 2 * A_LEN + T_GAP_DEF;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Main instance and its RTC model
  rtc_bus_ctrl_if bus_if ();
  logic ad, cs, rd, rw;
  tri1 [7:0] dato_sal;

  rtc_bus_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (bus_if),
    .AD       (ad),
    .CS       (cs),
    .RD       (rd),
    .RW       (rw),
    .Dato_sal (dato_sal)
  );

  logic [7:0] rtc_mem [256];
  logic [7:0] rtc_addr = 8'h00;
  assign dato_sal = (rd == 1'b0) ? rtc_mem[rtc_addr] : 8'hzz;

  // The RTC latches the address while selected in the address phase and
  // stores write data while selected with RW low in the data phase.
  always @(posedge clk) begin
    if (cs == 1'b0 && ad == 1'b0) rtc_addr = dato_sal;
    if (cs == 1'b0 && ad == 1'b1 && rw == 1'b0) rtc_mem[rtc_addr] = dato_sal;
  end

  // Minimum-timing instance with a fixed-value responder
  rtc_bus_ctrl_if bus_f ();
  logic f_ad, f_cs, f_rd, f_rw;
  tri1 [7:0] dato_f;
  assign dato_f = (f_rd == 1'b0) ? 8'hA5 : 8'hzz;

  rtc_bus_ctrl #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1), .CW(8)) dut_fast (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (bus_f),
    .AD       (f_ad),
    .CS       (f_cs),
    .RD       (f_rd),
    .RW       (f_rw),
    .Dato_sal (dato_f)
  );

  // Reference state
  logic [7:0] ref_mem [256];
  logic [7:0] last_rdata = 8'h00;
  txn_t sb_q[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic txn_t make_txn(input logic wr, input logic [7:0] a, input logic [7:0] wd);
    txn_t t;
    t.wr    = wr;
    t.addr  = a;
    t.wdata = wd;
    if (wr) begin
      ref_mem[a]  = wd;
      t.exp_rdata = last_rdata;
    end else begin
      t.exp_rdata = ref_mem[a];
      last_rdata  = ref_mem[a];
    end
    return t;
  endfunction

  // Expected {AD,CS,RD,RW,bus} for busy cycle k (1-based) of a transaction.
  function automatic logic [11:0] exp_pins(input int k, input txn_t t);
    int   d_pw_lo = A_LEN + T_GAP_DEF + T_SU_DEF;
    bit   in_addr = (k <= A_LEN);
    bit   in_apw  = (k > T_SU_DEF) && (k <= T_SU_DEF + T_PW_DEF);
    bit   in_dpw  = (k > d_pw_lo) && (k <= d_pw_lo + T_PW_DEF);
    logic [7:0] bus;
    if (in_addr)     bus = t.addr;
    else if (t.wr)   bus = t.wdata;
    else if (in_dpw) bus = t.exp_rdata;
    else             bus = 8'hFF;
    return {!in_addr, !(in_apw || in_dpw), !(in_dpw && !t.wr),
            !(in_apw || (in_dpw && t.wr)), bus};
  endfunction

  // Monitor: follows every cycle of the main instance and scores it.
  int   k = 0;
  txn_t cur = '0;
  logic prev_cs = 1'b1, prev_ad = 1'b1;
  logic [7:0] prev_bus = 8'hFF;

  always @(negedge clk) begin
    if (!rst) begin
      k       = 0;
      prev_cs = 1'b1;
    end else begin
      if (bus_if.busy) begin
        if (k == 0) begin
          if (sb_q.size() == 0) check_output("busy_without_request", sb_q.size(), 1);
          else cur = sb_q[0];
        end
        k++;
        check_output($sformatf("pins_k%0d", k), {ad, cs, rd, rw, dato_sal}, exp_pins(k, cur));
      end else begin
        if (bus_if.done) begin
          check_output("busy_len", k, BUSY_LEN);
          if (sb_q.size() == 0) begin
            check_output("spurious_done", sb_q.size(), 1);
          end else begin
            cur = sb_q.pop_front();
            check_output("rdata", bus_if.rdata, cur.exp_rdata);
          end
          k = 0;
        end
        check_output("idle_pins", {ad, cs, rd, rw, dato_sal}, 12'hFFF);
      end
      check_output("rd_rw_overlap", (!rd && !rw), 1'b0);
      check_output("cs_outside_pw", (!cs && rd && rw), 1'b0);
      if (!prev_cs && !cs) check_output("pw_stable", {ad, dato_sal}, {prev_ad, prev_bus});
      prev_cs  = cs;
      prev_ad  = ad;
      prev_bus = dato_sal;
    end
  end

  task automatic apply_stimulus(input logic wr, input logic [7:0] a, input logic [7:0] wd);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.wr_en = wr;
    bus_if.addr  = a;
    bus_if.wdata = wd;
    sb_q.push_back(make_txn(wr, a, wd));
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus_if.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.done !== 1'b1) check_output("done_timeout", bus_if.done, 1);
  endtask

  task automatic run_fast(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] exp_rd);
    int nb = 0, ncs = 0, nrd = 0, nrw = 0, ovl = 0, n = 0;
    bit seen = 0;
    @(negedge clk);
    bus_f.start = 1'b1;
    bus_f.wr_en = wr;
    bus_f.addr  = a;
    bus_f.wdata = wd;
    @(negedge clk);
    bus_f.start = 1'b0;
    while (!seen && n < 30) begin
      if (bus_f.busy) nb++;
      if (!f_cs) ncs++;
      if (!f_rd) nrd++;
      if (!f_rw) nrw++;
      if (!f_rd && !f_rw) ovl++;
      if (bus_f.done) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check_output("fast_done", seen, 1);
    check_output("fast_busy_len", nb, 7);
    check_output("fast_cs_low", ncs, 2);
    check_output("fast_rw_low", nrw, wr ? 2 : 1);
    check_output("fast_rd_low", nrd, wr ? 0 : 1);
    check_output("fast_overlap", ovl, 0);
    check_output("fast_rdata", bus_f.rdata, exp_rd);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      rtc_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    rtc_mem[8'h04] = 8'h12;
    ref_mem[8'h04] = 8'h12;
    bus_if.start = 1'b0; bus_if.wr_en = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    bus_f.start  = 1'b0; bus_f.wr_en  = 1'b0; bus_f.addr  = '0; bus_f.wdata  = '0;

    // Reset state
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_pins", {ad, cs, rd, rw, dato_sal}, 12'hFFF);
    check_output("reset_busy", bus_if.busy, 0);
    check_output("reset_done", bus_if.done, 0);
    check_output("reset_rdata", bus_if.rdata, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write and read
    apply_stimulus(1'b1, 8'h21, 8'h45);
    wait_done();
    apply_stimulus(1'b0, 8'h04, 8'h00);
    wait_done();

    // Start while busy is ignored
    apply_stimulus(1'b1, 8'h33, 8'h66);
    repeat (6) @(negedge clk);
    bus_if.start = 1'b1; bus_if.wr_en = 1'b0; bus_if.addr = 8'h99; bus_if.wdata = 8'h11;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("ignored_start_idle", bus_if.busy, 0);
    end

    // Start held through FIN: back-to-back with one non-busy cycle
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.wr_en = 1'b0; bus_if.addr = 8'h05; bus_if.wdata = 8'h00;
    sb_q.push_back(make_txn(1'b0, 8'h05, 8'h00));
    @(negedge clk);
    wait_done();
    bus_if.wr_en = 1'b1; bus_if.addr = 8'h06; bus_if.wdata = 8'h3C;
    sb_q.push_back(make_txn(1'b1, 8'h06, 8'h3C));
    @(negedge clk);
    bus_if.start = 1'b0;
    check_output("b2b_restart", bus_if.busy, 1);
    wait_done();

    // Reset in the middle of a write's data strobe
    apply_stimulus(1'b1, 8'h30, 8'h77);
    repeat (24) @(negedge clk);
    check_output("abort_in_dpw", {cs, rw}, 2'b00);
    #3 rst = 1'b0;
    #1;
    check_output("abort_pins", {ad, cs, rd, rw, dato_sal}, 12'hFFF);
    check_output("abort_busy", bus_if.busy, 0);
    check_output("abort_done", bus_if.done, 0);
    check_output("abort_rdata", bus_if.rdata, 8'h00);
    sb_q.delete();
    last_rdata = 8'h00;
    // The RTC model already stored the byte during the partial strobe.
    ref_mem[8'h30] = 8'h77;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b0, 8'h04, 8'h00);
    wait_done();

    // Randomized traffic over a small register window
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                     8'($urandom_range(0, 254)));
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Minimum timing instance
    run_fast(1'b1, 8'h10, 8'h20, 8'h00);
    run_fast(1'b0, 8'h10, 8'h00, 8'hA5);
    run_fast(1'b1, 8'h11, 8'h5C, 8'hA5);

    repeat (3) @(negedge clk);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
